gpio_conditioner: RTL and testbench

Parametrised input-conditioning stage between the FPGA pins and the PULPino SoC `gpio_in` bus. Each channel gets:
- a multi-stage synchroniser;
- a per-channel, runtime-enabled debounce filter;
- rising/falling edge capture into sticky pending flags, plus a single registered interrupt line.

It replaces direct pin-to-SoC wiring in the FPGA top level and scales to any channel count.

---
 rtl/gpio_conditioner.sv | 134 +++++++++++++
 tb/tb_gpio_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_conditioner.sv
// gpio_conditioner
// Input conditioning between FPGA pins and the SoC gpio_in bus. Every channel
// has a synchroniser chain, a runtime-enabled debounce filter and sticky
// edge-pending capture. A single registered interrupt line ORs the pending flags.
//
// After reset the block primes for SYNC_STAGES+1 cycles. During priming the
// stable value tracks the synchroniser output directly, so the pin state seen
// at reset release appears on gpio_o without being reported as an edge.
module gpio_conditioner #(
    parameter int NUM_GPIO    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_GPIO-1:0]   gpio_in,
    input  logic [NUM_GPIO-1:0]   debounce_en_i,
    input  logic [DEBOUNCE_W-1:0] debounce_limit_i,
    input  logic [NUM_GPIO-1:0]   irq_rise_en_i,
    input  logic [NUM_GPIO-1:0]   irq_fall_en_i,
    input  logic [NUM_GPIO-1:0]   irq_clr_i,
    output logic [NUM_GPIO-1:0]   gpio_o,
    output logic [NUM_GPIO-1:0]   pending_o,
    output logic                  irq_o
);

    // Wide enough to hold SYNC_STAGES+1 (max 5 for four stages).
    localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(SYNC_STAGES + 1);
    localparam logic [DEBOUNCE_W-1:0] CNT_ONE = DEBOUNCE_W'(1);

    logic [PRIME_W-1:0]  prime_cnt_reg;
    logic                priming;
    logic [NUM_GPIO-1:0] pending_vec;
    logic                irq_reg;

    // A shared limit of 0 behaves exactly like a limit of 1.
    logic [DEBOUNCE_W-1:0] shared_limit;
    assign shared_limit = (debounce_limit_i == '0) ? CNT_ONE : debounce_limit_i;

    assign priming = (prime_cnt_reg != '0);

    // Priming countdown; once it reaches zero the block stays in RUN until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt_reg <= PRIME_LOAD;
        end else if (priming) begin
            prime_cnt_reg <= prime_cnt_reg - PRIME_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GPIO; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   sync_last;
            logic                   stable_reg;
            logic                   stable_next;
            logic                   pending_reg;
            logic                   pending_next;
            logic [DEBOUNCE_W-1:0]  cnt_reg;
            logic [DEBOUNCE_W-1:0]  cnt_next;
            logic [DEBOUNCE_W-1:0]  eff_limit;
            logic                   rise_hit;
            logic                   fall_hit;

            assign sync_last = sync_reg[SYNC_STAGES-1];

            // Synchroniser chain: the pin enters at bit 0 and leaves at the top bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpio_in[gi]};
                end
            end

            // Debounce decision, edge detection and pending next-state.
            always_comb begin
                eff_limit    = debounce_en_i[gi] ? shared_limit : CNT_ONE;
                stable_next  = stable_reg;
                cnt_next     = cnt_reg;
                if (priming) begin
                    stable_next = sync_last;
                    cnt_next    = '0;
                end else if (sync_last == stable_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg >= eff_limit - CNT_ONE) begin
                    // The >= lets a limit lowered mid-count commit at once.
                    stable_next = sync_last;
                    cnt_next    = '0;
                end else if (cnt_reg != '1) begin
                    // Saturate rather than wrap on very long disagreements.
                    cnt_next = cnt_reg + CNT_ONE;
                end

                rise_hit = !priming && !stable_reg &&  stable_next && irq_rise_en_i[gi];
                fall_hit = !priming &&  stable_reg && !stable_next && irq_fall_en_i[gi];
                // A new edge wins over a clear arriving in the same cycle.
                pending_next = rise_hit || fall_hit || (pending_reg && !irq_clr_i[gi]);
            end

            // Per-channel state registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stable_reg  <= 1'b0;
                    cnt_reg     <= '0;
                    pending_reg <= 1'b0;
                end else begin
                    stable_reg  <= stable_next;
                    cnt_reg     <= cnt_next;
                    pending_reg <= pending_next;
                end
            end

            assign gpio_o[gi]      = stable_reg;
            assign pending_vec[gi] = pending_reg;
        end
    endgenerate

    assign pending_o = pending_vec;

    // Interrupt follows the registered pending flags one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |pending_vec;
        end
    end

    assign irq_o = irq_reg;

endmodule

// File: tb/tb_gpio_conditioner.sv
// tb_gpio_conditioner
// Directed bench: a table of settled-state vectors with no debounce, plus
// hand-written sequences for priming, latency, debounce, set/clear priority
// and asynchronous reset mid-operation.
module tb_gpio_conditioner;

    localparam int NG = 32;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NG-1:0] gpio_in;
    logic [NG-1:0] debounce_en_i;
    logic [DW-1:0] debounce_limit_i;
    logic [NG-1:0] irq_rise_en_i;
    logic [NG-1:0] irq_fall_en_i;
    logic [NG-1:0] irq_clr_i;
    logic [NG-1:0] gpio_o;
    logic [NG-1:0] pending_o;
    logic          irq_o;

    int errors = 0;
    int checks = 0;

    gpio_conditioner #(
        .NUM_GPIO    (NG),
        .SYNC_STAGES (2),
        .DEBOUNCE_W  (DW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .gpio_in          (gpio_in),
        .debounce_en_i    (debounce_en_i),
        .debounce_limit_i (debounce_limit_i),
        .irq_rise_en_i    (irq_rise_en_i),
        .irq_fall_en_i    (irq_fall_en_i),
        .irq_clr_i        (irq_clr_i),
        .gpio_o           (gpio_o),
        .pending_o        (pending_o),
        .irq_o            (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NG-1:0] gin;
        logic [NG-1:0] rise;
        logic [NG-1:0] fall;
        logic [NG-1:0] clr;
        logic [NG-1:0] exp_gpio;
        logic [NG-1:0] exp_pend;
        logic          exp_irq;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int found;

        vecs[0] = '{32'h0000_0000, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1] = '{32'h0000_0020, 32'h20, 32'h0, 32'h0, 32'h0000_0020, 32'h0000_0020, 1'b1};
        vecs[2] = '{32'h0000_0020, 32'h20, 32'h0, 32'h20, 32'h0000_0020, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'h0000_00A5, 32'hFF, 32'h0, 32'h0, 32'h0000_00A5, 32'h0000_0085, 1'b1};
        vecs[4] = '{32'h0000_0005, 32'h0, 32'h80, 32'h0, 32'h0000_0005, 32'h0000_0085, 1'b1};
        vecs[5] = '{32'h0000_0005, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'hF000_0005, 32'hA000_0000, 32'h0, 32'h0, 32'hF000_0005, 32'hA000_0000, 1'b1};
        vecs[7] = '{32'h0000_0000, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 32'hA000_0000, 1'b1};
        vecs[8] = '{32'h0000_0000, 32'h0, 32'h0, 32'hA000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};

        // ---------------- Reset and priming ----------------
        rst_n            = 1'b0;
        gpio_in          = '1;
        debounce_en_i    = '0;
        debounce_limit_i = '0;
        irq_rise_en_i    = '1;
        irq_fall_en_i    = '1;
        irq_clr_i        = '0;
        tick();
        tick();
        check("rst_gpio", gpio_o, 0);
        check("rst_pend", pending_o, 0);
        check("rst_irq", irq_o, 0);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 2) check("prime_gpio_e2", gpio_o, 0);
            if (e == 3) check("prime_gpio_e3", gpio_o, 32'hFFFF_FFFF);
            check("prime_pend", pending_o, 0);
            check("prime_irq", irq_o, 0);
        end
        $display("txn reset/prime: gpio_o=%h pending_o=%h irq_o=%b", gpio_o, pending_o, irq_o);

        // ---------------- Table-driven settled vectors ----------------
        for (int i = 0; i < 9; i++) begin
            gpio_in       = vecs[i].gin;
            irq_rise_en_i = vecs[i].rise;
            irq_fall_en_i = vecs[i].fall;
            irq_clr_i     = vecs[i].clr;
            repeat (4) tick();
            $display("txn vec%0d: gpio_in=%h gpio_o=%h pending_o=%h irq_o=%b",
                     i, vecs[i].gin, gpio_o, pending_o, irq_o);
            check($sformatf("vec%0d_gpio", i), gpio_o, vecs[i].exp_gpio);
            check($sformatf("vec%0d_pend", i), pending_o, vecs[i].exp_pend);
            check($sformatf("vec%0d_irq", i), irq_o, vecs[i].exp_irq);
        end
        irq_clr_i = '0;

        // ---------------- Latency without debounce, bit 5 ----------------
        irq_rise_en_i = 32'h20;
        irq_fall_en_i = '0;
        gpio_in       = 32'h20;
        tick();
        check("lat_e1_gpio", gpio_o[5], 0);
        tick();
        check("lat_e2_gpio", gpio_o[5], 0);
        tick();
        check("lat_e3_gpio", gpio_o[5], 1);
        check("lat_e3_pend", pending_o[5], 1);
        check("lat_e3_irq", irq_o, 0);
        tick();
        check("lat_e4_irq", irq_o, 1);
        $display("txn latency bit5: gpio_o=%h pending_o=%h irq_o=%b", gpio_o, pending_o, irq_o);
        gpio_in   = '0;
        irq_clr_i = '1;
        repeat (4) tick();
        irq_clr_i = '0;
        tick();

        // ---------------- Debounce, limit 8, bit 0 ----------------
        debounce_limit_i = 16'd8;
        debounce_en_i    = 32'h1;
        irq_rise_en_i    = 32'h1;
        gpio_in          = 32'h1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 7) gpio_in = '0;
            if (e == 9) check("db7_cnt_e9", dut.g_ch[0].cnt_reg, 7);
            if (e == 10) check("db7_cnt_e10", dut.g_ch[0].cnt_reg, 0);
            check("db7_gpio", gpio_o[0], 0);
        end
        check("db7_pend", pending_o[0], 0);
        $display("txn debounce 7-cycle pulse: gpio_o=%h pending_o=%h", gpio_o, pending_o);

        found   = 0;
        gpio_in = 32'h1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 10) gpio_in = '0;
            if (gpio_o[0]) begin
                found = k;
                break;
            end
        end
        check("db10_latency", found, 10);
        check("db10_pend", pending_o[0], 1);
        repeat (15) tick();
        check("db10_fall_gpio", gpio_o[0], 0);
        $display("txn debounce 10-cycle pulse: rise after %0d edges", found);
        irq_clr_i = '1;
        tick();
        irq_clr_i     = '0;
        debounce_en_i = '0;
        tick();

        // ---------------- Edge-type selection, bit 3 ----------------
        irq_rise_en_i = '0;
        irq_fall_en_i = 32'h8;
        gpio_in       = 32'h8;
        repeat (4) tick();
        check("sel_rise_gpio", gpio_o[3], 1);
        check("sel_rise_pend", pending_o, 0);
        gpio_in = '0;
        repeat (4) tick();
        check("sel_fall_pend", pending_o, 32'h8);
        $display("txn edge select bit3: pending_o=%h", pending_o);

        // ---------------- Simultaneous set and clear ----------------
        gpio_in = 32'h8;
        repeat (4) tick();
        check("sc_pre_pend", pending_o, 32'h8);
        gpio_in = '0;
        tick();
        tick();
        irq_clr_i = 32'h8;
        tick();
        check("sc_commit_gpio", gpio_o[3], 0);
        check("sc_setwins_pend", pending_o, 32'h8);
        tick();
        check("sc_clr_pend", pending_o, 0);
        check("sc_clr_irq_hold", irq_o, 1);
        irq_clr_i = '0;
        tick();
        check("sc_irq_fall", irq_o, 0);
        $display("txn set/clear bit3: pending_o=%h irq_o=%b", pending_o, irq_o);

        // ---------------- Reset mid-operation ----------------
        irq_rise_en_i = 32'h8;
        irq_fall_en_i = 32'h8;
        gpio_in       = 32'h8;
        repeat (4) tick();
        debounce_limit_i = 16'd8;
        debounce_en_i    = 32'h1;
        gpio_in          = 32'h9;
        repeat (7) tick();
        check("mid_pre_cnt", dut.g_ch[0].cnt_reg, 5);
        check("mid_pre_pend", pending_o, 32'h8);
        check("mid_pre_gpio", gpio_o, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gpio", gpio_o, 0);
        check("mid_rst_pend", pending_o, 0);
        check("mid_rst_irq", irq_o, 0);
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 2) check("mid_prime_gpio_e2", gpio_o, 0);
            if (e == 3) check("mid_prime_gpio_e3", gpio_o, 32'h9);
            check("mid_prime_pend", pending_o, 0);
            check("mid_prime_irq", irq_o, 0);
        end
        $display("txn reset mid-op: gpio_o=%h pending_o=%h irq_o=%b", gpio_o, pending_o, irq_o);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
